operand_fetch: RTL and testbench
================================

# operand_fetch

Operand-fetch stage directly upstream of the ALU shift unit: holds the architectural register file, decodes each incoming instruction word into func/rs1/rs2/rd/imm fields, reads both source operands (with same-cycle writeback bypass) and presents them to the execute stage through a one-entry valid/ready pipeline register. Its outputs drive the shift unit's `rs1_data_i`, `rs2_data_i`, `func_i` and `imm` inputs. Writeback results return on a dedicated write port.

## Interface
- `DATA_WIDTH`, default `simple_processor_pkg::DATA_WIDTH` (32): register and operand width.
- `NUM_REGS`, default 32: register count; address width `AW = $clog2(NUM_REGS)` (5).
- `clk_i`  in  1  clock, all state on rising edge.
- `arst_i`  in  1  reset; asynchronous, active-high.
- `instr_i`  in  32  instruction word:
  - `[3:0]` func
  - `[8:4]` rd
  - `[13:9]` rs1
  - `[18:14]` rs2
  - `[24:19]` imm
  - `[31:25]` ignored
- `instr_valid_i`  in  1  instruction present.
- `instr_ready_o`  out  1  stage accepts instruction this cycle.
- `wb_en_i`  in  1  register write enable.
- `wb_addr_i`  in  AW  write address.
- `wb_data_i`  in  DATA_WIDTH  write data.
- `rs1_data_o`  out  DATA_WIDTH  operand 1 to execute.
- `rs2_data_o`  out  DATA_WIDTH  operand 2 to execute.
- `func_o`  out  4  function code (SLL/SLLI/SLR/SLRI and others from package, passed unmodified).
- `imm_o`  out  6  raw 6-bit immediate; execute sign-extends.
- `rd_addr_o`  out  AW  destination register.
- `valid_o`  out  1  output bundle valid.
- `ready_i`  in  1  execute stage accepts bundle.

## Operation
- Register file: NUM_REGS x DATA_WIDTH flops, combinational read.
  - Register 0 reads 0 always; writes to address 0 are discarded.
- Write port: on a rising edge with `wb_en_i`=1 and `wb_addr_i`!=0, `regs[wb_addr_i] <= wb_data_i`.
- Read bypass: if `wb_en_i`=1, `wb_addr_i`!=0 and `wb_addr_i` equals rs1 (or rs2), the captured operand is `wb_data_i`, not the stale file content.
- `instr_ready_o = !valid_o || ready_i` (combinational; no dependence on `instr_valid_i`).
- Capture: `instr_valid_i && instr_ready_o` at an edge loads the output register with:
  - decoded func, rd and imm;
  - bypassed rs1/rs2 data;
  - `valid_o <= 1`.
- Drain: `valid_o && ready_i` with no new capture sets `valid_o <= 0`. Simultaneous drain and capture keeps `valid_o=1` with the new bundle (full throughput, one per cycle).
- Stall (`valid_o=1`, `ready_i=0`):
  - All outputs hold.
  - Exception: if a writeback targets the held bundle's rs1 (or rs2) address (nonzero), that operand register updates to `wb_data_i` at the same edge. The bundle therefore always reflects the latest architectural value.
  - The held rs1/rs2 addresses are stored internally for this purpose.
- Func codes are not checked; unknown codes pass through unchanged.

## Timing
- Latency: instruction accepted at edge N, bundle visible on outputs after edge N, consumed no earlier than edge N+1.
- Reset (async assert, sync-safe release):
  - `valid_o=0`, `rs1_data_o=0`, `rs2_data_o=0`, `func_o=0`, `imm_o=0`, `rd_addr_o=0`;
  - all registers = 0;
  - `instr_ready_o=1` after reset.
- Reset mid-stall discards the held bundle immediately; no partial writeback is retained from the reset cycle.
- Writeback to register R at edge N is visible to an instruction captured at edge N (bypass) and any later edge.
- Outputs change only on clock edges or reset; no combinational path from `instr_i` to the bundle outputs.

## Test plan
- Reset then write regs: write x5=0x0000_00F0, x6=0x0000_0004; issue SLL rs1=5 rs2=6 rd=7 with `ready_i`=1 -> next cycle `valid_o`=1, `rs1_data_o`=0xF0, `rs2_data_o`=4, `func_o`=SLL, `rd_addr_o`=7.
- Same-cycle bypass: `wb_en_i`=1, x3=0xDEAD_BEEF in the same cycle as an instruction reading rs1=3 -> `rs1_data_o`=0xDEAD_BEEF.
- x0 behaviour: write x0=0xFFFF_FFFF, then read rs1=0, rs2=0 -> both operands 0, including when the write coincides with the capture.
- Backpressure: hold `ready_i`=0 for 5 cycles with a valid bundle; `instr_ready_o`=0 and outputs stable. A writeback of x5=0x1234 during the stall updates `rs1_data_o` to 0x1234. Releasing `ready_i` accepts the next instruction the same edge.
- Throughput: 100 back-to-back random SLLI/SLRI/SLL/SLR instructions with `ready_i`=1 -> one bundle per cycle, and fields match the decoded `instr_i`.
- Async reset during stall: assert `arst_i` between edges -> `valid_o` falls immediately; all outputs and registers read 0 afterwards.

Source files
------------

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch (with simple_processor_pkg)
// Description : Operand-fetch stage. Holds the architectural register file,
//               decodes the instruction word, reads both sources with a
//               same-cycle writeback bypass and hands a bundle to execute
//               through a one-entry valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================

package simple_processor_pkg;
  localparam int DATA_WIDTH = 32;

  // Shift-unit function codes; any other code is passed through untouched.
  localparam logic [3:0] FUNC_SLL  = 4'd1;
  localparam logic [3:0] FUNC_SLLI = 4'd2;
  localparam logic [3:0] FUNC_SLR  = 4'd3;
  localparam logic [3:0] FUNC_SLRI = 4'd4;
endpackage

module operand_fetch #(
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = 32,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [31:0]           instr_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic                  wb_en_i,
  input  logic [AW-1:0]         wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  output logic [3:0]            func_o,
  output logic [5:0]            imm_o,
  output logic [AW-1:0]         rd_addr_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  // Decoded instruction fields
  logic [3:0]            dec_func;
  logic [AW-1:0]         dec_rd;
  logic [AW-1:0]         dec_rs1;
  logic [AW-1:0]         dec_rs2;
  logic [5:0]            dec_imm;
  logic                  unused_instr_bits;

  // Register file and read path
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wb_hit;
  logic [DATA_WIDTH-1:0] rs1_read;
  logic [DATA_WIDTH-1:0] rs2_read;

  // Source addresses of the bundle currently held on the outputs
  logic [AW-1:0]         held_rs1;
  logic [AW-1:0]         held_rs2;
  logic                  capture;

  assign dec_func          = instr_i[3:0];
  assign dec_rd            = instr_i[4 +: AW];
  assign dec_rs1           = instr_i[9 +: AW];
  assign dec_rs2           = instr_i[14 +: AW];
  assign dec_imm           = instr_i[24:19];
  assign unused_instr_bits = ^instr_i[31:25];

  // Writes to x0 are dropped here so x0 never holds anything but zero.
  assign wb_hit = wb_en_i && (wb_addr_i != '0);

  // Source read with x0 forced to zero and same-cycle writeback bypass
  always_comb begin
    rs1_read = '0;
    rs2_read = '0;
    if (dec_rs1 != '0) begin
      rs1_read = (wb_hit && (wb_addr_i == dec_rs1)) ? wb_data_i : regs[dec_rs1];
    end
    if (dec_rs2 != '0) begin
      rs2_read = (wb_hit && (wb_addr_i == dec_rs2)) ? wb_data_i : regs[dec_rs2];
    end
  end

  // Accept a new instruction whenever the output slot is empty or draining.
  assign instr_ready_o = !valid_o || ready_i;
  assign capture       = instr_valid_i && instr_ready_o;

  // Architectural register file write port
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_hit) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  end

  // Output bundle register: capture, drain, and refresh of held operands
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      valid_o    <= 1'b0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      func_o     <= '0;
      imm_o      <= '0;
      rd_addr_o  <= '0;
      held_rs1   <= '0;
      held_rs2   <= '0;
    end else if (capture) begin
      valid_o    <= 1'b1;
      rs1_data_o <= rs1_read;
      rs2_data_o <= rs2_read;
      func_o     <= dec_func;
      imm_o      <= dec_imm;
      rd_addr_o  <= dec_rd;
      held_rs1   <= dec_rs1;
      held_rs2   <= dec_rs2;
    end else if (valid_o) begin
      // A held bundle tracks writebacks so it never carries a stale operand.
      if (wb_hit && (wb_addr_i == held_rs1)) begin
        rs1_data_o <= wb_data_i;
      end
      if (wb_hit && (wb_addr_i == held_rs2)) begin
        rs2_data_o <= wb_data_i;
      end
      if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Directed self-checking bench for operand_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;
  import simple_processor_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic [3:0]  func_o;
  logic [5:0]  imm_o;
  logic [4:0]  rd_addr_o;
  logic        valid_o;
  logic        ready_i;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [32];

  operand_fetch dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .wb_en_i       (wb_en_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .rs1_data_o    (rs1_data_o),
    .rs2_data_o    (rs2_data_o),
    .func_o        (func_o),
    .imm_o         (imm_o),
    .rd_addr_o     (rd_addr_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] f, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [5:0] imm);
    return {7'h0, imm, rs2, rs1, rd, f};
  endfunction

  task automatic check_bundle(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [3:0] f, input logic [4:0] rd, input logic [5:0] imm);
    check_eq({tag, ".valid"}, {31'b0, valid_o}, 32'd1);
    check_eq({tag, ".rs1"}, rs1_data_o, r1);
    check_eq({tag, ".rs2"}, rs2_data_o, r2);
    check_eq({tag, ".func"}, {28'b0, func_o}, {28'b0, f});
    check_eq({tag, ".rd"}, {27'b0, rd_addr_o}, {27'b0, rd});
    check_eq({tag, ".imm"}, {26'b0, imm_o}, {26'b0, imm});
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".valid"}, {31'b0, valid_o}, 32'd0);
    check_eq({tag, ".rs1"}, rs1_data_o, 32'd0);
    check_eq({tag, ".rs2"}, rs2_data_o, 32'd0);
    check_eq({tag, ".func"}, {28'b0, func_o}, 32'd0);
    check_eq({tag, ".imm"}, {26'b0, imm_o}, 32'd0);
    check_eq({tag, ".rd"}, {27'b0, rd_addr_o}, 32'd0);
    check_eq({tag, ".irdy"}, {31'b0, instr_ready_o}, 32'd1);
  endtask

  initial begin
    logic [3:0]  f;
    logic [4:0]  a1, a2, rd;
    logic [5:0]  imm;
    logic [31:0] e1, e2;

    arst_i = 1'b1; instr_i = '0; instr_valid_i = 1'b0; ready_i = 1'b1;
    wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_idle("reset");
    arst_i = 1'b0;

    // Register writes then a basic SLL fetch
    wb_en_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'h0000_00F0; tick();
    wb_addr_i = 5'd6; wb_data_i = 32'h0000_0004; tick();
    wb_en_i = 1'b0;
    instr_i = mk(FUNC_SLL, 5'd7, 5'd5, 5'd6, 6'h2A); instr_valid_i = 1'b1; tick();
    check_bundle("sll", 32'hF0, 32'h4, FUNC_SLL, 5'd7, 6'h2A);
    instr_valid_i = 1'b0; tick();
    check_eq("drain.valid", {31'b0, valid_o}, 32'd0);

    // Same-cycle bypass, then a later plain read of the same register
    wb_en_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'hDEAD_BEEF;
    instr_i = mk(FUNC_SLR, 5'd1, 5'd3, 5'd5, 6'h05); instr_valid_i = 1'b1; tick();
    check_bundle("bypass", 32'hDEAD_BEEF, 32'hF0, FUNC_SLR, 5'd1, 6'h05);
    wb_en_i = 1'b0;
    instr_i = mk(4'hF, 5'd2, 5'd6, 5'd3, 6'h3F); tick();
    check_bundle("unkfunc", 32'h4, 32'hDEAD_BEEF, 4'hF, 5'd2, 6'h3F);

    // x0 stays zero, both with coincident write and afterwards
    wb_en_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hFFFF_FFFF;
    instr_i = mk(FUNC_SLL, 5'd4, 5'd0, 5'd0, 6'h00); tick();
    check_bundle("x0_same", 32'h0, 32'h0, FUNC_SLL, 5'd4, 6'h00);
    wb_en_i = 1'b0; tick();
    check_bundle("x0_after", 32'h0, 32'h0, FUNC_SLL, 5'd4, 6'h00);
    instr_valid_i = 1'b0; tick();

    // Backpressure with a writeback to the held rs1
    ready_i = 1'b0;
    instr_i = mk(FUNC_SLLI, 5'd9, 5'd5, 5'd6, 6'h3F); instr_valid_i = 1'b1; tick();
    check_bundle("stall0", 32'hF0, 32'h4, FUNC_SLLI, 5'd9, 6'h3F);
    instr_i = mk(FUNC_SLRI, 5'd10, 5'd6, 5'd5, 6'h01);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        wb_en_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'h0000_1234;
      end
      tick();
      wb_en_i = 1'b0;
      check_bundle("stall", (i >= 2) ? 32'h1234 : 32'hF0, 32'h4, FUNC_SLLI, 5'd9, 6'h3F);
      check_eq("stall.irdy", {31'b0, instr_ready_o}, 32'd0);
    end
    ready_i = 1'b1; #1;
    check_eq("release.irdy", {31'b0, instr_ready_o}, 32'd1);
    tick();
    check_bundle("release", 32'h4, 32'h1234, FUNC_SLRI, 5'd10, 6'h01);

    // Back-to-back random shift instructions with random writebacks
    for (int r = 0; r < 32; r++) model[r] = 32'h0;
    model[3] = 32'hDEAD_BEEF; model[5] = 32'h1234; model[6] = 32'h4;
    for (int n = 0; n < 100; n++) begin
      case ($urandom_range(0, 3))
        0:       f = FUNC_SLL;
        1:       f = FUNC_SLLI;
        2:       f = FUNC_SLR;
        default: f = FUNC_SLRI;
      endcase
      a1 = 5'($urandom); a2 = 5'($urandom); rd = 5'($urandom); imm = 6'($urandom);
      wb_en_i = 1'($urandom); wb_addr_i = 5'($urandom); wb_data_i = $urandom;
      instr_i = mk(f, rd, a1, a2, imm) | ($urandom & 32'hFE00_0000);
      e1 = (a1 == 0) ? 32'h0 : (wb_en_i && wb_addr_i == a1) ? wb_data_i : model[a1];
      e2 = (a2 == 0) ? 32'h0 : (wb_en_i && wb_addr_i == a2) ? wb_data_i : model[a2];
      if (wb_en_i && wb_addr_i != 0) model[wb_addr_i] = wb_data_i;
      tick();
      check_bundle("b2b", e1, e2, f, rd, imm);
    end
    wb_en_i = 1'b0;

    // Asynchronous reset while stalled
    ready_i = 1'b0; instr_i = mk(FUNC_SLL, 5'd2, 5'd5, 5'd6, 6'h11); tick();
    check_eq("prerst.valid", {31'b0, valid_o}, 32'd1);
    #2 arst_i = 1'b1;
    #1 check_idle("async_rst");
    #1 arst_i = 1'b0;
    ready_i = 1'b1; instr_i = mk(FUNC_SLL, 5'd2, 5'd5, 5'd3, 6'h11); tick();
    check_bundle("postrst", 32'h0, 32'h0, FUNC_SLL, 5'd2, 6'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
